// File: rtl/seg_decode_pkg.sv
// Shared constants for the seven-segment scan decoder: active-low segment patterns,
// the per-sample scan FSM states and a helper to locate the selected digit.
package seg_decode_pkg;

    localparam logic [6:0] SEG_PAT_0     = 7'h40;
    localparam logic [6:0] SEG_PAT_1     = 7'h79;
    localparam logic [6:0] SEG_PAT_2     = 7'h24;
    localparam logic [6:0] SEG_PAT_3     = 7'h30;
    localparam logic [6:0] SEG_PAT_4     = 7'h19;
    localparam logic [6:0] SEG_PAT_5     = 7'h12;
    localparam logic [6:0] SEG_PAT_6     = 7'h02;
    localparam logic [6:0] SEG_PAT_7     = 7'h78;
    localparam logic [6:0] SEG_PAT_8     = 7'h00;
    localparam logic [6:0] SEG_PAT_9     = 7'h10;
    localparam logic [6:0] SEG_PAT_A     = 7'h08;
    localparam logic [6:0] SEG_PAT_B     = 7'h03;
    localparam logic [6:0] SEG_PAT_C     = 7'h46;
    localparam logic [6:0] SEG_PAT_D     = 7'h21;
    localparam logic [6:0] SEG_PAT_E     = 7'h06;
    localparam logic [6:0] SEG_PAT_F     = 7'h0E;
    localparam logic [6:0] SEG_PAT_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } scan_state_t;

    // Anodes are active-low; callers only use this when exactly one bit is low.
    function automatic logic [1:0] digit_index(input logic [3:0] an_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!an_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seven_seg_scan_decoder_if.sv
// Frame delivery bus of the scan decoder: decoded digits, per-digit flags and a
// valid/ready handshake. The decoder drives it as master, the consumer as slave.
interface seven_seg_scan_decoder_if;

    logic [15:0] out_digits;
    logic [3:0]  out_blank;
    logic [3:0]  out_invalid;
    logic        out_overrun;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output out_digits, out_blank, out_invalid, out_overrun, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_digits, out_blank, out_invalid, out_overrun, out_valid,
        output out_ready
    );

endinterface

// File: rtl/seg_pattern_decoder.sv
// Combinational lookup from an active-low segment pattern to a 4-bit value.
// Letters A-F are only recognised when SEG_HEX_EN is defined.
module seg_pattern_decoder
    import seg_decode_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] value_o,
    output logic       blank_o,
    output logic       invalid_o
);

    always_comb begin
        value_o   = 4'h0;
        blank_o   = 1'b0;
        invalid_o = 1'b0;
        case (seg_i)
            SEG_PAT_0:     value_o = 4'h0;
            SEG_PAT_1:     value_o = 4'h1;
            SEG_PAT_2:     value_o = 4'h2;
            SEG_PAT_3:     value_o = 4'h3;
            SEG_PAT_4:     value_o = 4'h4;
            SEG_PAT_5:     value_o = 4'h5;
            SEG_PAT_6:     value_o = 4'h6;
            SEG_PAT_7:     value_o = 4'h7;
            SEG_PAT_8:     value_o = 4'h8;
            SEG_PAT_9:     value_o = 4'h9;
`ifdef SEG_HEX_EN
            SEG_PAT_A:     value_o = 4'hA;
            SEG_PAT_B:     value_o = 4'hB;
            SEG_PAT_C:     value_o = 4'hC;
            SEG_PAT_D:     value_o = 4'hD;
            SEG_PAT_E:     value_o = 4'hE;
            SEG_PAT_F:     value_o = 4'hF;
`endif
            SEG_PAT_BLANK: blank_o = 1'b1;
            default:       invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Recovers four-digit frames from a multiplexed active-low seg/an display bus.
// Hex letters decode only when SEG_HEX_EN is defined (see seg_pattern_decoder).
module seven_seg_scan_decoder
    import seg_decode_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [6:0]                      seg,
    input  logic [3:0]                      an,
    seven_seg_scan_decoder_if.master        frame_if
);

    localparam logic [7:0] STABLE_L = 8'(STABLE_CYCLES);

    logic [6:0]      seg_meta_q, seg_sync_q, seg_prev_q;
    logic [3:0]      an_meta_q, an_sync_q, an_prev_q;
    scan_state_t     state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            capture, selected, same, frame_load;
    logic [1:0]      cap_idx;
    logic [3:0]      dec_val;
    logic            dec_blank, dec_invalid;
    logic [3:0][3:0] work_val_q;
    logic [3:0]      work_blank_q, work_inv_q, seen_q, seen_d;
    logic [15:0]     out_digits_q;
    logic [3:0]      out_blank_q, out_invalid_q;
    logic            out_valid_q, out_overrun_q;

    // Idle level of the bus is all-ones, so the synchronizer and history reset there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_meta_q <= '1;
            seg_sync_q <= '1;
            seg_prev_q <= '1;
            an_meta_q  <= '1;
            an_sync_q  <= '1;
            an_prev_q  <= '1;
        end else begin
            seg_meta_q <= seg;
            seg_sync_q <= seg_meta_q;
            seg_prev_q <= seg_sync_q;
            an_meta_q  <= an;
            an_sync_q  <= an_meta_q;
            an_prev_q  <= an_sync_q;
        end
    end

    assign selected = $onehot(~an_sync_q);
    assign same     = (an_sync_q == an_prev_q) && (seg_sync_q == seg_prev_q);
    assign cap_idx  = digit_index(an_sync_q);

    seg_pattern_decoder u_decoder (
        .seg_i     (seg_sync_q),
        .value_o   (dec_val),
        .blank_o   (dec_blank),
        .invalid_o (dec_invalid)
    );

    // The counter includes the current sample, so reaching STABLE_L means
    // STABLE_CYCLES identical samples; HOLD blocks a second capture of the same dwell.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (selected) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d   = 8'd0;
                end
            end
            SETTLE: begin
                if (!selected) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (!same) begin
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    if (cnt_d == STABLE_L) begin
                        state_d = HOLD;
                        capture = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!same) begin
                    state_d = selected ? SETTLE : IDLE;
                    cnt_d   = selected ? 8'd1 : 8'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    assign frame_load = (seen_q == 4'hF);

    always_comb begin
        seen_d = frame_load ? 4'h0 : seen_q;
        if (capture) seen_d[cap_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            seen_q       <= 4'h0;
            work_val_q   <= '0;
            work_blank_q <= 4'h0;
            work_inv_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            if (capture) begin
                work_val_q[cap_idx]   <= dec_val;
                work_blank_q[cap_idx] <= dec_blank;
                work_inv_q[cap_idx]   <= dec_invalid;
            end
        end
    end

    // A completed frame always loads; overrun only when it displaces an unaccepted one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_digits_q  <= 16'h0;
            out_blank_q   <= 4'h0;
            out_invalid_q <= 4'h0;
            out_valid_q   <= 1'b0;
            out_overrun_q <= 1'b0;
        end else if (frame_load) begin
            out_digits_q  <= work_val_q;
            out_blank_q   <= work_blank_q;
            out_invalid_q <= work_inv_q;
            out_valid_q   <= 1'b1;
            out_overrun_q <= out_valid_q && !frame_if.out_ready;
        end else if (out_valid_q && frame_if.out_ready) begin
            out_valid_q   <= 1'b0;
        end
    end

    assign frame_if.out_digits  = out_digits_q;
    assign frame_if.out_blank   = out_blank_q;
    assign frame_if.out_invalid = out_invalid_q;
    assign frame_if.out_valid   = out_valid_q;
    assign frame_if.out_overrun = out_overrun_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Self-checking bench for seven_seg_scan_decoder: drives timed dwells on seg/an and
// predicts frames and their arrival cycle from the pin timeline (honours SEG_HEX_EN).
module tb_seven_seg_scan_decoder;

    localparam int S = 16;
`ifdef SEG_HEX_EN
    localparam int NUM_DECODED = 16;
`else
    localparam int NUM_DECODED = 10;
`endif

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] digits;
        logic [3:0]  blank;
        logic [3:0]  invalid;
        logic        overrun;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  an;
    int unsigned cycleCnt = 0;
    int          checks, errors;
    bit          monEn;
    frame_t      expQ[$];
    frame_t      actQ[$];
    logic [3:0]  mVal[4];
    logic [3:0]  mBlank, mInv, mSeen;
    logic [3:0]  lastAn;
    logic [6:0]  lastSeg;
    logic [6:0]  patTable[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seven_seg_scan_decoder_if busIf ();

    seven_seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .seg      (seg),
        .an       (an),
        .frame_if (busIf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Every accepted transfer is logged with the cycle in which it was presented.
    always @(negedge clk) begin
        if (monEn && busIf.out_valid && busIf.out_ready)
            actQ.push_back('{cycleCnt, busIf.out_digits, busIf.out_blank,
                             busIf.out_invalid, busIf.out_overrun});
    end

    function automatic void decodeRef(input logic [6:0] p, output logic [3:0] v,
                                      output logic b, output logic inv);
        v = 4'h0;
        b = 1'b0;
        inv = 1'b1;
        if (p == 7'h7F) begin
            b = 1'b1;
            inv = 1'b0;
        end else begin
            for (int k = 0; k < NUM_DECODED; k++) begin
                if (patTable[k] == p) begin
                    v = 4'(k);
                    inv = 1'b0;
                end
            end
        end
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) mVal[i] = 4'h0;
        mBlank = 4'h0;
        mInv = 4'h0;
        mSeen = 4'h0;
        lastAn = 4'hF;
        lastSeg = 7'h7F;
        expQ.delete();
        actQ.delete();
    endtask

    // Holds (a, s) on the pins for len cycles; a selected dwell of at least S cycles
    // is captured S+2 cycles after it starts and a full frame appears one cycle later.
    task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int len);
        int unsigned start;
        int idx;
        logic [3:0] v;
        logic b, inv;
        @(negedge clk);
        rst = 1'b0;
        an = a;
        seg = s;
        start = cycleCnt;
        if ($countones(~a) == 1 && len >= S) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
            decodeRef(s, v, b, inv);
            mVal[idx] = v;
            mBlank[idx] = b;
            mInv[idx] = inv;
            mSeen[idx] = 1'b1;
            if (mSeen == 4'hF) begin
                expQ.push_back('{32'(start + 3 + S), {mVal[3], mVal[2], mVal[1], mVal[0]},
                                 mBlank, mInv, 1'b0});
                mSeen = 4'h0;
            end
        end
        lastAn = a;
        lastSeg = s;
        repeat (len - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        an = 4'b1110;
        seg = 7'h40;
        repeat (5) @(negedge clk);
        checks++;
        if ({busIf.out_valid, busIf.out_digits, busIf.out_blank, busIf.out_invalid,
             busIf.out_overrun} !== 26'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b dig=%h blank=%b inv=%b ovr=%b, expected all 0",
                     busIf.out_valid, busIf.out_digits, busIf.out_blank, busIf.out_invalid,
                     busIf.out_overrun);
        end
        modelReset();
        dwell(4'b1110, 7'h40, 20);
        dwell(4'b1101, 7'h79, 20);
        dwell(4'b1011, 7'h24, 20);
        dwell(4'b0111, 7'h30, 20);
        dwell(4'b1111, 7'h7F, 10);
        checks++;
        if (actQ.size() != expQ.size()) begin
            errors++;
            $display("[TB] FAIL reset_frame_count: got %0d, expected %0d", actQ.size(), expQ.size());
        end
        for (int i = 0; i < actQ.size() && i < expQ.size(); i++) begin
            checks++;
            if (actQ[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL reset_frame%0d: got cyc=%0d dig=%h bl=%b inv=%b ovr=%b, expected cyc=%0d dig=%h bl=%b inv=%b ovr=%b",
                         i, actQ[i].cyc, actQ[i].digits, actQ[i].blank, actQ[i].invalid, actQ[i].overrun,
                         expQ[i].cyc, expQ[i].digits, expQ[i].blank, expQ[i].invalid, expQ[i].overrun);
            end
        end
        modelReset();
    endtask

    task automatic test_scan_basic();
        dwell(4'b0111, 7'h79, 20);
        dwell(4'b1011, 7'h24, 20);
        dwell(4'b1101, 7'h30, 20);
        dwell(4'b1110, 7'h19, 20);
        dwell(4'b1111, 7'h7F, 10);
        checks++;
        if (actQ.size() != 1) begin
            errors++;
            $display("[TB] FAIL basic_frame_count: got %0d, expected 1", actQ.size());
        end
        for (int i = 0; i < actQ.size() && i < expQ.size(); i++) begin
            checks++;
            if (actQ[i] !== expQ[i] || actQ[i].digits !== 16'h1234) begin
                errors++;
                $display("[TB] FAIL basic_frame%0d: got cyc=%0d dig=%h bl=%b inv=%b ovr=%b, expected cyc=%0d dig=1234 bl=0000 inv=0000 ovr=0",
                         i, actQ[i].cyc, actQ[i].digits, actQ[i].blank, actQ[i].invalid,
                         actQ[i].overrun, expQ[i].cyc);
            end
        end
        modelReset();
    endtask

    task automatic test_short_dwell();
        dwell(4'b0111, 7'h12, S - 1);
        dwell(4'b1011, 7'h02, S - 1);
        dwell(4'b1101, 7'h78, S - 1);
        dwell(4'b1110, 7'h00, S - 1);
        dwell(4'b1100, 7'h40, 100);
        dwell(4'b1110, 7'h10, 20);
        dwell(4'b1101, 7'h00, 20);
        dwell(4'b1011, 7'h78, 20);
        dwell(4'b1111, 7'h7F, 10);
        checks++;
        if (actQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL short_dwell_no_frame: got %0d frames, expected 0", actQ.size());
        end
        dwell(4'b0111, 7'h02, 20);
        dwell(4'b1111, 7'h7F, 10);
        checks++;
        if (actQ.size() != expQ.size()) begin
            errors++;
            $display("[TB] FAIL short_frame_count: got %0d, expected %0d", actQ.size(), expQ.size());
        end
        for (int i = 0; i < actQ.size() && i < expQ.size(); i++) begin
            checks++;
            if (actQ[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL short_frame%0d: got cyc=%0d dig=%h, expected cyc=%0d dig=%h",
                         i, actQ[i].cyc, actQ[i].digits, expQ[i].cyc, expQ[i].digits);
            end
        end
        modelReset();
    endtask

    task automatic test_flags();
        logic [3:0]  expInv;
        logic [15:0] expDig;
`ifdef SEG_HEX_EN
        expInv = 4'b0010;
        expDig = 16'hAA00;
`else
        expInv = 4'b1110;
        expDig = 16'h0000;
`endif
        dwell(4'b1110, 7'h7F, 20);
        dwell(4'b1101, 7'h7E, 20);
        dwell(4'b1011, 7'h08, 20);
        dwell(4'b0111, 7'h08, 20);
        dwell(4'b1111, 7'h7F, 10);
        checks++;
        if (actQ.size() != expQ.size()) begin
            errors++;
            $display("[TB] FAIL flags_frame_count: got %0d, expected %0d", actQ.size(), expQ.size());
        end
        for (int i = 0; i < actQ.size() && i < expQ.size(); i++) begin
            checks++;
            if (actQ[i] !== expQ[i] || actQ[i].blank !== 4'b0001 || actQ[i].invalid !== expInv
                || actQ[i].digits !== expDig) begin
                errors++;
                $display("[TB] FAIL flags_frame%0d: got cyc=%0d dig=%h bl=%b inv=%b, expected cyc=%0d dig=%h bl=0001 inv=%b",
                         i, actQ[i].cyc, actQ[i].digits, actQ[i].blank, actQ[i].invalid,
                         expQ[i].cyc, expDig, expInv);
            end
        end
        modelReset();
    endtask

    task automatic test_overrun();
        monEn = 1'b0;
        busIf.out_ready = 1'b0;
        dwell(4'b0111, 7'h79, 20);
        dwell(4'b1011, 7'h24, 20);
        dwell(4'b1101, 7'h30, 20);
        dwell(4'b1110, 7'h19, 20);
        checks++;
        if ({busIf.out_valid, busIf.out_digits, busIf.out_overrun} !== {1'b1, 16'h1234, 1'b0}) begin
            errors++;
            $display("[TB] FAIL first_held_frame: got valid=%b dig=%h ovr=%b, expected valid=1 dig=1234 ovr=0",
                     busIf.out_valid, busIf.out_digits, busIf.out_overrun);
        end
        dwell(4'b0111, 7'h12, 20);
        dwell(4'b1011, 7'h02, 20);
        checks++;
        if ({busIf.out_valid, busIf.out_digits} !== {1'b1, 16'h1234}) begin
            errors++;
            $display("[TB] FAIL held_frame_stable: got valid=%b dig=%h, expected valid=1 dig=1234",
                     busIf.out_valid, busIf.out_digits);
        end
        dwell(4'b1101, 7'h78, 20);
        dwell(4'b1110, 7'h00, 20);
        checks++;
        if ({busIf.out_valid, busIf.out_digits, busIf.out_overrun} !== {1'b1, 16'h5678, 1'b1}) begin
            errors++;
            $display("[TB] FAIL overrun_frame: got valid=%b dig=%h ovr=%b, expected valid=1 dig=5678 ovr=1",
                     busIf.out_valid, busIf.out_digits, busIf.out_overrun);
        end
        busIf.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (busIf.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL valid_after_accept: got %b, expected 0", busIf.out_valid);
        end
        dwell(4'b1111, 7'h7F, 10);
        monEn = 1'b1;
        modelReset();
    endtask

    task automatic test_mid_reset();
        dwell(4'b0111, 7'h30, 20);
        dwell(4'b1011, 7'h19, 20);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busIf.out_valid, busIf.out_digits, busIf.out_blank, busIf.out_invalid,
             busIf.out_overrun} !== 26'h0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got valid=%b dig=%h blank=%b inv=%b ovr=%b, expected all 0",
                     busIf.out_valid, busIf.out_digits, busIf.out_blank, busIf.out_invalid,
                     busIf.out_overrun);
        end
        modelReset();
        dwell(4'b1110, 7'h02, 20);
        dwell(4'b1101, 7'h78, 20);
        dwell(4'b1011, 7'h00, 20);
        dwell(4'b0111, 7'h10, 20);
        dwell(4'b1111, 7'h7F, 10);
        checks++;
        if (actQ.size() != 1) begin
            errors++;
            $display("[TB] FAIL midreset_frame_count: got %0d, expected 1", actQ.size());
        end
        for (int i = 0; i < actQ.size() && i < expQ.size(); i++) begin
            checks++;
            if (actQ[i] !== expQ[i] || actQ[i].digits !== 16'h9876) begin
                errors++;
                $display("[TB] FAIL midreset_frame%0d: got cyc=%0d dig=%h, expected cyc=%0d dig=9876",
                         i, actQ[i].cyc, actQ[i].digits, expQ[i].cyc);
            end
        end
        modelReset();
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [6:0] s;
        int len;
        for (int n = 0; n < 120; n++) begin
            do begin
                if ($urandom_range(0, 9) < 2) begin
                    do a = 4'($urandom); while ($countones(~a) == 1);
                    s = 7'($urandom);
                    len = $urandom_range(1, 12);
                end else begin
                    a = ~(4'b0001 << $urandom_range(0, 3));
                    case ($urandom_range(0, 3))
                        0: s = 7'($urandom);
                        1: s = 7'h7F;
                        default: s = patTable[$urandom_range(0, 15)];
                    endcase
                    len = $urandom_range(S - 3, S + 8);
                end
            end while (a == lastAn && s == lastSeg);
            dwell(a, s, len);
        end
        dwell(4'b1111, 7'h7F, 10);
        checks++;
        if (actQ.size() != expQ.size()) begin
            errors++;
            $display("[TB] FAIL random_frame_count: got %0d, expected %0d", actQ.size(), expQ.size());
        end
        for (int i = 0; i < actQ.size() && i < expQ.size(); i++) begin
            checks++;
            if (actQ[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL random_frame%0d: got cyc=%0d dig=%h bl=%b inv=%b ovr=%b, expected cyc=%0d dig=%h bl=%b inv=%b ovr=%b",
                         i, actQ[i].cyc, actQ[i].digits, actQ[i].blank, actQ[i].invalid, actQ[i].overrun,
                         expQ[i].cyc, expQ[i].digits, expQ[i].blank, expQ[i].invalid, expQ[i].overrun);
            end
        end
        modelReset();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        monEn = 1'b1;
        rst = 1'b1;
        an = 4'hF;
        seg = 7'h7F;
        busIf.out_ready = 1'b1;
        modelReset();
        test_reset();
        test_scan_basic();
        test_short_dwell();
        test_flags();
        test_overrun();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/seven_seg_scan_decoder.md
# seven_seg_scan_decoder

Receive-side counterpart to the board's 7-segment display drivers: it watches a multiplexed active-low `seg`/`an` bus and recovers the displayed characters. It filters per-digit patterns for stability, decodes them back to 4-bit values, and delivers a complete four-digit frame over a valid/ready handshake. It is used for loopback self-test of display-driving designs and for capturing display traffic from another board.

## Interface
- `STABLE_CYCLES`, default 16: number of consecutive identical synchronized samples required before a digit is captured. Legal range is 2..255.
- `clk` input, 1 bit: system clock.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `seg` input, 7 bits: segment lines, active-low, bit0 = a through bit6 = g. `7'b1000000` is "0".
- `an` input, 4 bits: anode enables, active-low. Bit i selects digit i, and `an[3]` is the leftmost digit.
- `out_digits` output, 16 bits: decoded values, digit i at bits [4i+3:4i].
- `out_blank` output, 4 bits: digit i was captured as all-off (`7'b1111111`).
- `out_invalid` output, 4 bits: digit i was captured with an undecodable pattern.
- `out_overrun` output, 1 bit: an unaccepted frame was replaced by this one.
- `out_valid` output, 1 bit: frame available.
- `out_ready` input, 1 bit: consumer accepts the frame.

## Operation
- `seg` and `an` pass through a 2-flop synchronizer. All processing below uses the synchronized values `s_seg` and `s_an`.
- A sample is "selected" only when `s_an` has exactly one bit low. All-high, or more than one bit low, is "unselected".
- The per-sample FSM has three states:
  - IDLE, entered on an unselected sample. The counter is cleared.
  - SETTLE. The counter increments while (`s_an`, `s_seg`) equals the previous sample. Any change, including a change to a different selected pattern, reloads the counter to 1.
  - HOLD, entered when the counter reaches `STABLE_CYCLES`. On the entering edge the digit is captured. The FSM stays in HOLD until the sample changes, then goes to SETTLE (selected) or IDLE (unselected).
- Exactly one capture occurs per stable dwell.
- A capture of digit i writes:
  - the decoded value into the digit-i working register;
  - the blank and invalid flags for digit i;
  - `seen[i]` = 1.
- If digit i is recaptured before the frame completes, the newest capture overwrites it.
- Decode table, active-low, as hex of `seg[6:0]`:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10
  - A = 08, b = 03, C = 46, d = 21, E = 06, F = 0E
  - blank = 7F gives value 0 with the blank flag set.
  - Any other pattern gives value 0 with the invalid flag set.
- Frame completion happens when `seen` becomes 4'b1111:
  - the working registers are copied into the output registers;
  - `seen` is cleared;
  - `out_valid` is set.
- Handshake: the frame transfers on a cycle with `out_valid && out_ready`. `out_valid` drops the next cycle unless a new frame completes on that same cycle.
- Output registers are stable while `out_valid && !out_ready`.
- If a frame completes while `out_valid && !out_ready`:
  - the new frame replaces the held one;
  - `out_overrun` = 1;
  - `out_valid` stays 1.
- If a frame completes on the same cycle as an accepting handshake, the new frame loads with `out_valid` = 1 and `out_overrun` = 0.
- `out_overrun` is cleared whenever a frame loads with no unaccepted predecessor.

## Timing
- Reset values: all outputs are 0, the synchronizer flops reset to 1 (inactive), `seen` is 0, and the FSM is in IDLE.
- Reset asserted mid-frame discards partial captures and any held frame.
- Capture latency: a pin pattern stable from cycle t is captured at the edge ending cycle t + 1 + `STABLE_CYCLES`.
- Frame to `out_valid` latency is 1 cycle after the capture that completes `seen`.
- The block has no combinational path from inputs to outputs. `out_ready` affects only the next state.

## Configuration
- Macro `SEG_HEX_EN`:
  - Defined: patterns A–F decode to values 10–15.
  - Undefined: only 0–9 and blank are recognized. The A–F patterns set the invalid flag with value 0.

## Structure
- Package `seg_decode_pkg` holds:
  - the sixteen pattern localparams `SEG_PAT_0` .. `SEG_PAT_F` and `SEG_PAT_BLANK`;
  - the FSM state enum `scan_state_t` (IDLE, SETTLE, HOLD).
- Sub-module `seg_pattern_decoder` is the combinational lookup: `seg[6:0]` in; value[3:0], blank, invalid out. It is also `SEG_HEX_EN`-aware.

## Test plan
- Reset: with `rst` high, drive `seg` = 40 and `an` = 1110 → all outputs stay 0. Release reset; the first capture must not occur before 2 + 16 cycles.
- Scan digits 3..0 showing 1, 2, 3, 4, dwelling 20 cycles each with `out_ready` = 1 → one `out_valid` pulse, `out_digits` = 16'h1234, and all flags 0.
- Dwell of 15 cycles per digit → no captures, `out_valid` never asserts. `an` = 1100 held for 100 cycles → no capture.
- Digit 0 = 7F, digit 1 = 7E, digits 2–3 = 08 → `out_blank` = 0001.
  - With `SEG_HEX_EN`: `out_invalid` = 0010 and digit 2 = A.
  - Without it: `out_invalid` = 1110.
- Hold `out_ready` = 0 over two complete frames, 1234 then 5678 → `out_digits` = 5678 with `out_overrun` = 1. Raise `out_ready` → one-cycle transfer, then `out_valid` = 0.
- Assert `rst` after two digits have been captured → all outputs 0. The next full scan produces exactly one frame containing only post-reset values.
